// File: rtl/chunk_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : chunk_fetch
// Description : Map-side producer of the per-pixel chunk code. Converts the
//               VGA scan position into a map RAM tile address, issues the
//               read, sanitises the returned code and delivers one 4-bit
//               chunk code per pixel through a fixed 3-cycle pipeline.
//               Pixels outside the playfield and invalid stored codes are
//               emitted as `SIDE.
// Ports       : clk, rst          - clock (rising edge), async active-high reset
//               pix_x, pix_y      - current scan column / row (10 bit)
//               pix_valid         - scan position is in the visible area
//               map_addr          - map RAM read address (registered)
//               map_rd_en         - map RAM read strobe (registered)
//               map_data          - map RAM read data, one cycle after address
//               chunk_type        - chunk code for the pixel of 3 cycles ago
//               chunk_valid       - chunk_type belongs to a visible pixel
// Options     : CHUNK_GRID_EN     - draw tile grid lines (first row/column of
//                                   every tile) as `SIDE
// Revision    : 1.0 - initial release
// ============================================================================

// Chunk code defines. A project-wide chunk-type header included earlier in
// the compilation takes precedence over these fall-back values.
`ifndef PLAYER_UP
`define PLAYER_UP    4'd0
`endif
`ifndef PLAYER_DOWN
`define PLAYER_DOWN  4'd1
`endif
`ifndef PLAYER_LEFT
`define PLAYER_LEFT  4'd2
`endif
`ifndef PLAYER_RIGHT
`define PLAYER_RIGHT 4'd3
`endif
`ifndef BOX
`define BOX          4'd4
`endif
`ifndef TARGET
`define TARGET       4'd5
`endif
`ifndef WALL
`define WALL         4'd6
`endif
`ifndef GROUND
`define GROUND       4'd7
`endif
`ifndef SIDE
`define SIDE         4'd8
`endif

module chunk_fetch #(
   parameter int MAP_W     = 16,
   parameter int MAP_H     = 12,
   parameter int TILE_LOG2 = 5,
   parameter int X_OFF     = 64,
   parameter int Y_OFF     = 48,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [9:0]        pix_x,
   input  logic [9:0]        pix_y,
   input  logic              pix_valid,
   output logic [ADDR_W-1:0] map_addr,
   output logic              map_rd_en,
   input  logic [3:0]        map_data,
   output logic [3:0]        chunk_type,
   output logic              chunk_valid
);

   localparam logic [9:0] c_x_off   = 10'(X_OFF);
   localparam logic [9:0] c_y_off   = 10'(Y_OFF);
   localparam logic [9:0] c_map_wpx = 10'(MAP_W << TILE_LOG2);
   localparam logic [9:0] c_map_hpx = 10'(MAP_H << TILE_LOG2);

   // ------------------------------------------------------------------
   // Stage 0: position decode (combinational)
   // ------------------------------------------------------------------
   logic [9:0]        w_rel_x;
   logic [9:0]        w_rel_y;
   logic [9:0]        w_tx;
   logic [9:0]        w_ty;
   logic              w_in_map;
   logic [ADDR_W-1:0] w_addr_d;

   assign w_rel_x = pix_x - c_x_off;
   assign w_rel_y = pix_y - c_y_off;

   // The lower-bound compare uses the raw position so a column left of the
   // playfield cannot wrap into the map through the subtraction.
   assign w_in_map = pix_valid
                   & (pix_x >= c_x_off) & (pix_y >= c_y_off)
                   & (w_rel_x < c_map_wpx) & (w_rel_y < c_map_hpx);

   assign w_tx     = w_rel_x >> TILE_LOG2;
   assign w_ty     = w_rel_y >> TILE_LOG2;
   assign w_addr_d = ADDR_W'(32'(w_ty) * 32'(MAP_W) + 32'(w_tx));

   // ------------------------------------------------------------------
   // Stage 1/2 pipeline and output registers
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] map_addr_q;
   logic              map_rd_en_q;
   logic              valid1_q;
   logic              inmap1_q;
   logic              valid2_q;
   logic              inmap2_q;
   logic [3:0]        chunk_type_q;
   logic              chunk_valid_q;
   logic [3:0]        w_chunk_d;
   logic              w_code_ok;
   logic              w_on_grid2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         map_addr_q    <= '0;
         map_rd_en_q   <= 1'b0;
         valid1_q      <= 1'b0;
         inmap1_q      <= 1'b0;
         valid2_q      <= 1'b0;
         inmap2_q      <= 1'b0;
         chunk_type_q  <= `SIDE;
         chunk_valid_q <= 1'b0;
      end else begin
         map_rd_en_q <= w_in_map;
         // Address only moves for real reads; the RAM ignores it otherwise.
         if (w_in_map) begin
            map_addr_q <= w_addr_d;
         end
         valid1_q      <= pix_valid;
         inmap1_q      <= w_in_map;
         valid2_q      <= valid1_q;
         inmap2_q      <= inmap1_q;
         chunk_type_q  <= w_chunk_d;
         chunk_valid_q <= valid2_q;
      end
   end

`ifdef CHUNK_GRID_EN
   // Grid flag travels alongside the in-map bit; the read is still issued.
   logic w_grid0;
   logic grid1_q;
   logic grid2_q;

   assign w_grid0 = (w_rel_x[TILE_LOG2-1:0] == '0) | (w_rel_y[TILE_LOG2-1:0] == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grid1_q <= 1'b0;
         grid2_q <= 1'b0;
      end else begin
         grid1_q <= w_grid0;
         grid2_q <= grid1_q;
      end
   end

   assign w_on_grid2 = grid2_q;
`else
   assign w_on_grid2 = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Stage 2: sanitise the returned code
   // ------------------------------------------------------------------
   always_comb begin
      w_code_ok = 1'b0;
      case (map_data)
         `PLAYER_UP, `PLAYER_DOWN, `PLAYER_LEFT, `PLAYER_RIGHT,
         `BOX, `TARGET, `WALL, `GROUND, `SIDE: w_code_ok = 1'b1;
         default:                              w_code_ok = 1'b0;
      endcase
   end

   assign w_chunk_d = (inmap2_q && !w_on_grid2 && w_code_ok) ? map_data : `SIDE;

   assign map_addr    = map_addr_q;
   assign map_rd_en   = map_rd_en_q;
   assign chunk_type  = chunk_type_q;
   assign chunk_valid = chunk_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_chunk_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_chunk_fetch
// Description : Self-checking bench for chunk_fetch. A map RAM model answers
//               the DUT reads; a per-pixel reference model predicts the
//               read strobe/address one cycle later and the chunk code three
//               cycles later. Directed scenarios are followed by random scans.
// Options     : CHUNK_GRID_EN     - expects tile grid lines as `SIDE
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef PLAYER_UP
`define PLAYER_UP    4'd0
`endif
`ifndef PLAYER_DOWN
`define PLAYER_DOWN  4'd1
`endif
`ifndef PLAYER_LEFT
`define PLAYER_LEFT  4'd2
`endif
`ifndef PLAYER_RIGHT
`define PLAYER_RIGHT 4'd3
`endif
`ifndef BOX
`define BOX          4'd4
`endif
`ifndef TARGET
`define TARGET       4'd5
`endif
`ifndef WALL
`define WALL         4'd6
`endif
`ifndef GROUND
`define GROUND       4'd7
`endif
`ifndef SIDE
`define SIDE         4'd8
`endif

module tb_chunk_fetch;

   localparam int MAP_W = 16;
   localparam int MAP_H = 12;
   localparam int TILE  = 32;
   localparam int X_OFF = 64;
   localparam int Y_OFF = 48;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic       pix_valid;
   logic [7:0] map_addr;
   logic       map_rd_en;
   logic [3:0] map_data;
   logic [3:0] chunk_type;
   logic       chunk_valid;

   always #5 clk = ~clk;

   chunk_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_valid   (pix_valid),
      .map_addr    (map_addr),
      .map_rd_en   (map_rd_en),
      .map_data    (map_data),
      .chunk_type  (chunk_type),
      .chunk_valid (chunk_valid)
   );

   // Synchronous-read map RAM
   logic [3:0] mem [0:255];
   always @(posedge clk) begin
      if (map_rd_en) map_data <= mem[map_addr];
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: one entry per pixel presented
   typedef struct {
      bit rd;
      int addr;
      int chunk;
      bit vld;
   } exp_t;

   exp_t q[$];
   int   last_addr;

   function automatic logic [3:0] sane(input logic [3:0] v);
      if (v == `PLAYER_UP || v == `PLAYER_DOWN || v == `PLAYER_LEFT ||
          v == `PLAYER_RIGHT || v == `BOX || v == `TARGET || v == `WALL ||
          v == `GROUND || v == `SIDE)
         return v;
      return `SIDE;
   endfunction

   task automatic model_push(input int x, input int y, input bit v);
      exp_t e;
      bit   inm;
      bit   grid;
      inm = v && x >= X_OFF && x < X_OFF + MAP_W * TILE &&
            y >= Y_OFF && y < Y_OFF + MAP_H * TILE;
      grid = 1'b0;
`ifdef CHUNK_GRID_EN
      grid = ((x - X_OFF) % TILE == 0) || ((y - Y_OFF) % TILE == 0);
`endif
      if (inm) last_addr = ((y - Y_OFF) / TILE) * MAP_W + (x - X_OFF) / TILE;
      e.rd    = inm;
      e.addr  = last_addr;
      e.chunk = (inm && !grid) ? int'(sane(mem[last_addr])) : int'(`SIDE);
      e.vld   = v;
      q.push_back(e);
      if (q.size() > 8) void'(q.pop_front());
   endtask

   task automatic reset_model();
      exp_t e;
      q.delete();
      last_addr = 0;
      e.rd = 1'b0; e.addr = 0; e.chunk = int'(`SIDE); e.vld = 1'b0;
      repeat (3) q.push_back(e);
   endtask

   task automatic check_outputs();
      exp_t e1;
      exp_t e3;
      e1 = q[q.size() - 1];
      e3 = q[q.size() - 3];
      check_eq("map_rd_en",   32'(map_rd_en),   32'(e1.rd));
      check_eq("map_addr",    32'(map_addr),    32'(e1.addr));
      check_eq("chunk_type",  32'(chunk_type),  32'(e3.chunk));
      check_eq("chunk_valid", 32'(chunk_valid), 32'(e3.vld));
   endtask

   task automatic drive(input int x, input int y, input bit v);
      @(negedge clk);
      check_outputs();
      pix_x     = 10'(x);
      pix_y     = 10'(y);
      pix_valid = v;
      model_push(x, y, v);
   endtask

   task automatic check_reset_vals();
      check_eq("rst_chunk_type",  32'(chunk_type),  32'(`SIDE));
      check_eq("rst_chunk_valid", 32'(chunk_valid), 32'd0);
      check_eq("rst_map_rd_en",   32'(map_rd_en),   32'd0);
      check_eq("rst_map_addr",    32'(map_addr),    32'd0);
   endtask

   // Assert reset mid-cycle (inputs untouched), hold, then release with idle inputs.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_vals();
      @(negedge clk);
      check_reset_vals();
      pix_valid = 1'b0;
      pix_x     = '0;
      pix_y     = '0;
      rst       = 1'b0;
      reset_model();
      model_push(0, 0, 1'b0);
   endtask

   logic [3:0] codes [0:8];

   initial begin
      codes[0] = `PLAYER_UP;    codes[1] = `PLAYER_DOWN; codes[2] = `PLAYER_LEFT;
      codes[3] = `PLAYER_RIGHT; codes[4] = `BOX;         codes[5] = `TARGET;
      codes[6] = `WALL;         codes[7] = `GROUND;      codes[8] = `SIDE;
      for (int i = 0; i < 256; i++) begin
         if ($urandom_range(0, 4) == 0) mem[i] = 4'($urandom_range(0, 15));
         else                           mem[i] = codes[$urandom_range(0, 8)];
      end
      mem[0] = `WALL;
      mem[1] = `GROUND;
      mem[2] = 4'hF;
      mem[3] = `BOX;

      map_data  = '0;
      rst       = 1'b1;
      pix_valid = 1'b0;
      pix_x     = '0;
      pix_y     = '0;
      do_reset();

      // First tile, last tile, interior address
      drive(64, 48, 1);
      drive(575, 431, 1);
      drive(96, 80, 1);
      // Streaming across tiles 0 and 1
      for (int x = 64; x < 128; x++) drive(x, 48, 1);
      // Outside the map and invisible pixels
      drive(63, 100, 1);
      drive(576, 100, 1);
      drive(100, 47, 1);
      drive(100, 432, 1);
      drive(100, 100, 0);
      drive(0, 0, 1);
      // Sanitising: invalid code followed by BOX
      drive(130, 50, 1);
      drive(170, 50, 1);
      // Grid line pixel and interior pixel of tile 1
      drive(96, 60, 1);
      drive(97, 61, 1);
      // Mid-stream reset with valid pixels in flight
      drive(200, 200, 1);
      drive(201, 200, 1);
      do_reset();
      drive(300, 300, 1);
      drive(301, 300, 1);
      drive(302, 300, 1);

      // Random scan
      for (int i = 0; i < 3000; i++) begin
         int x;
         int y;
         if ($urandom_range(0, 1) == 0) begin
            x = $urandom_range(40, 600);
            y = $urandom_range(30, 450);
         end else begin
            x = $urandom_range(0, 799);
            y = $urandom_range(0, 524);
         end
         drive(x, y, $urandom_range(0, 9) != 0);
      end

      // Drain the pipeline
      repeat (4) drive(0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
